// File: rtl/eth_tx_sched_pkg.sv
// Shared Steelhorse constants for the Ethernet transmit scheduler: FSM
// encodings, interface register addresses and the maximum send length.
package eth_tx_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_START  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [9:0] SH_LEN_ADDR  = 10'h00a;
  localparam logic [9:0] SH_IDLE_ADDR = 10'h009;
  localparam logic [9:0] SH_MAX_LEN   = 10'd512;
  localparam int         DESC_W       = 10;

  // Lengths above the Steelhorse buffer size are rejected without starting.
  function automatic logic len_too_long(input logic [DESC_W-1:0] len);
    return len > SH_MAX_LEN;
  endfunction

endpackage

// File: rtl/eth_tx_descq.sv
// Synchronous descriptor FIFO with show-ahead head output; pointers carry an
// extra wrap bit so full and empty are distinguishable without a counter.
module eth_tx_descq #(
  parameter int WIDTH = 10,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [2**AW];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Fullness is judged on the registered pointers, so a same-cycle pop
  // never frees a slot for the incoming write.
  assign do_wr = wr_en && !full && !rst;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/eth_tx_sched.sv
// Queues transmit descriptors and sequences each one into the Steelhorse:
// program the send length, pulse RUN, track BUSY and report completion.
module eth_tx_sched
  import eth_tx_sched_pkg::*;
#(
  parameter int         QDEPTH_LOG2 = 2,
  parameter int         START_TMO   = 1023,
  parameter logic [9:0] LEN_ADDR    = SH_LEN_ADDR,
  parameter logic [9:0] IDLE_ADDR   = SH_IDLE_ADDR
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [9:0]             DESC_IN,
  input  logic                   DESC_WRITE,
  output logic                   DESC_FULL,
  output logic [9:0]             INTRFC_ADDR,
  output logic [15:0]            INTRFC_DATA,
  output logic                   RUN,
  input  logic                   BUSY,
  output logic                   DONE_IRQ,
  output logic                   ERR_IRQ,
  output logic                   OVERFLOW,
  output logic [QDEPTH_LOG2:0]   PENDING,
  output state_t                 fsm_state
);

  localparam int               TMO_W    = $clog2(START_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(START_TMO - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(START_TMO);

  state_t              state;
  state_t              state_nx;
  logic [DESC_W-1:0]   len_q;
  logic                load_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic                err_q;
  logic                err_set;
  logic                overflow_q;
  logic                pop;
  logic [DESC_W-1:0]   q_head;
  logic                q_full;
  logic                q_empty;

  // Enqueue handshake: DESC_IN is taken on any edge where DESC_WRITE=1 and
  // DESC_FULL=0 (outside reset); a write while full is dropped and flagged.
  eth_tx_descq #(
    .WIDTH (DESC_W),
    .AW    (QDEPTH_LOG2)
  ) u_descq (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (DESC_WRITE),
    .wr_data (DESC_IN),
    .rd_en   (pop),
    .rd_data (q_head),
    .full    (q_full),
    .empty   (q_empty),
    .count   (PENDING)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      len_q      <= '0;
      load_cnt   <= 1'b0;
      tmo_cnt    <= '0;
      err_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state    <= state_nx;
      load_cnt <= (state == ST_LOAD) && !load_cnt;
      err_q    <= err_set;
      if (pop) len_q <= q_head;
      if (DESC_WRITE && q_full) overflow_q <= 1'b1;
      // Held at zero outside START so every START begins from a clean count.
      if (state != ST_START) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt != TMO_MAX) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
    end
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    err_set  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!q_empty) begin
          pop = 1'b1;
          if (q_head == '0) begin
            state_nx = ST_DONE;
          end else if (len_too_long(q_head)) begin
            err_set = 1'b1;
          end else begin
            state_nx = ST_LOAD;
          end
        end
      end
      ST_LOAD:   if (load_cnt) state_nx = ST_SETTLE;
      ST_SETTLE: state_nx = ST_START;
      ST_START: begin
        if (BUSY) begin
          state_nx = ST_WAIT;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nx = ST_IDLE;
          err_set  = 1'b1;
        end
      end
      ST_WAIT:   if (!BUSY) state_nx = ST_DONE;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  assign INTRFC_ADDR = (state == ST_LOAD) ? LEN_ADDR : IDLE_ADDR;
  assign INTRFC_DATA = {6'h0, len_q};
  assign RUN         = (state == ST_START) || (state == ST_WAIT);
  assign DONE_IRQ    = (state == ST_DONE);
  assign ERR_IRQ     = err_q;
  assign OVERFLOW    = overflow_q;
  assign DESC_FULL   = q_full;
  assign fsm_state   = state;

endmodule

// File: tb/tb_eth_tx_sched.sv
// Bench for eth_tx_sched: a Steelhorse BUSY responder, a completion monitor
// feeding a scoreboard, a single-descriptor vector table and directed cases.
module tb_eth_tx_sched;
  import eth_tx_sched_pkg::*;

  logic        CLK;
  logic        RST;
  logic [9:0]  DESC_IN;
  logic        DESC_WRITE;
  logic        DESC_FULL;
  logic [9:0]  INTRFC_ADDR;
  logic [15:0] INTRFC_DATA;
  logic        RUN;
  logic        BUSY;
  logic        DONE_IRQ;
  logic        ERR_IRQ;
  logic        OVERFLOW;
  logic [2:0]  PENDING;
  state_t      fsm_state;

  eth_tx_sched dut (
    .CLK         (CLK),
    .RST         (RST),
    .DESC_IN     (DESC_IN),
    .DESC_WRITE  (DESC_WRITE),
    .DESC_FULL   (DESC_FULL),
    .INTRFC_ADDR (INTRFC_ADDR),
    .INTRFC_DATA (INTRFC_DATA),
    .RUN         (RUN),
    .BUSY        (BUSY),
    .DONE_IRQ    (DONE_IRQ),
    .ERR_IRQ     (ERR_IRQ),
    .OVERFLOW    (OVERFLOW),
    .PENDING     (PENDING),
    .fsm_state   (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- scoreboard state ----------------
  // Completion record: {kind(1=done,2=err), ran, load_cycles, programmed_data}
  logic [20:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_cyc = -100;
  int          mon_loads = 0;
  int          mon_runcnt = 0;
  int          mon_last_run = 0;
  logic        mon_ran = 1'b0;
  logic [15:0] mon_data = '0;
  logic        prev_load = 1'b0;
  logic        busy_en = 1'b1;
  int          busy_cycles = 5;

  typedef struct {
    logic [9:0]  len;
    int          busy;
    logic [20:0] exp;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [20:0] mk(input logic [1:0] k, input logic r,
                                     input logic [1:0] l, input logic [15:0] d);
    return {k, r, l, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- Steelhorse BUSY responder ----------------
  initial begin
    BUSY = 1'b0;
    forever begin
      @(negedge CLK);
      if (RUN && busy_en && !BUSY) begin
        repeat (2) @(negedge CLK);
        BUSY = 1'b1;
        repeat (busy_cycles) @(negedge CLK);
        BUSY = 1'b0;
      end
    end
  end

  // ---------------- completion monitor ----------------
  initial begin
    logic [20:0] obs;
    logic [20:0] e;
    forever begin
      @(negedge CLK);
      cyc++;
      if (INTRFC_ADDR == 10'h00a) begin
        if (!prev_load) chk("done_to_load_gap", 32'(cyc - done_cyc >= 2), 32'd1);
        if (mon_loads < 3) mon_loads++;
        mon_data  = INTRFC_DATA;
        prev_load = 1'b1;
      end else begin
        prev_load = 1'b0;
      end
      if (RUN) begin
        mon_ran = 1'b1;
        mon_runcnt++;
      end
      if (DONE_IRQ || ERR_IRQ) begin
        obs = {(DONE_IRQ ? 2'd1 : 2'd2), mon_ran, 2'(mon_loads), mon_data};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion actual=%0h expected=none", obs);
        end else begin
          e = exp_q.pop_front();
          chk("completion", 32'(obs), 32'(e));
        end
        if (DONE_IRQ) done_cyc = cyc;
        mon_last_run = mon_runcnt;
        mon_runcnt   = 0;
        mon_ran      = 1'b0;
        mon_loads    = 0;
        mon_data     = '0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_desc(input logic [9:0] len, input logic accept, input logic [20:0] exp);
    DESC_IN    = len;
    DESC_WRITE = 1'b1;
    if (accept) exp_q.push_back(exp);
    @(negedge CLK);
    DESC_WRITE = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || fsm_state != ST_IDLE || PENDING != 0) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s_drain_timeout actual=%0d expected<%0d", name, n, budget);
      exp_q.delete();
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic wait_state(input string name, input state_t s, input int budget);
    int n = 0;
    while (fsm_state != s && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s_state_timeout actual=%0d expected=%0d", name, fsm_state, s);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{10'd16,  20, mk(2'd1, 1'b1, 2'd2, 16'h0010)};
    vecs[1] = '{10'd5,    1, mk(2'd1, 1'b1, 2'd2, 16'h0005)};
    vecs[2] = '{10'd0,    1, mk(2'd1, 1'b0, 2'd0, 16'h0000)};
    vecs[3] = '{10'd600,  1, mk(2'd2, 1'b0, 2'd0, 16'h0000)};
    vecs[4] = '{10'd512,  3, mk(2'd1, 1'b1, 2'd2, 16'h0200)};
    vecs[5] = '{10'd513,  1, mk(2'd2, 1'b0, 2'd0, 16'h0000)};
    vecs[6] = '{10'd1,    7, mk(2'd1, 1'b1, 2'd2, 16'h0001)};

    RST        = 1'b1;
    DESC_WRITE = 1'b0;
    DESC_IN    = '0;
    repeat (3) @(negedge CLK);
    chk("rst_state",    32'(fsm_state),   32'(ST_IDLE));
    chk("rst_run",      32'(RUN),         32'd0);
    chk("rst_addr",     32'(INTRFC_ADDR), 32'h009);
    chk("rst_data",     32'(INTRFC_DATA), 32'h0000);
    chk("rst_done",     32'(DONE_IRQ),    32'd0);
    chk("rst_err",      32'(ERR_IRQ),     32'd0);
    chk("rst_overflow", 32'(OVERFLOW),    32'd0);
    chk("rst_pending",  32'(PENDING),     32'd0);
    chk("rst_full",     32'(DESC_FULL),   32'd0);
    RST = 1'b0;
    @(negedge CLK);

    // Single descriptors: normal lengths, zero length and oversize lengths.
    for (int i = 0; i < 7; i++) begin
      busy_cycles = vecs[i].busy;
      write_desc(vecs[i].len, 1'b1, vecs[i].exp);
      wait_drain("vec", 4000);
    end

    // Two back-to-back descriptors: second is queued while the first runs.
    busy_cycles = 20;
    write_desc(10'd16, 1'b1, mk(2'd1, 1'b1, 2'd2, 16'h0010));
    write_desc(10'd5,  1'b1, mk(2'd1, 1'b1, 2'd2, 16'h0005));
    chk("b2b_pending_after_writes", 32'(PENDING), 32'd1);
    wait_state("b2b_wait", ST_WAIT, 200);
    chk("b2b_pending_in_wait", 32'(PENDING), 32'd1);
    wait_drain("b2b", 4000);
    chk("b2b_pending_end", 32'(PENDING), 32'd0);

    // Overfill the queue while the first descriptor holds BUSY.
    busy_cycles = 60;
    write_desc(10'd16, 1'b1, mk(2'd1, 1'b1, 2'd2, 16'h0010));
    wait_state("ovf_wait", ST_WAIT, 200);
    for (int i = 0; i < 5; i++) begin
      write_desc(10'(3 + i), (i < 4), mk(2'd1, 1'b1, 2'd2, 16'(3 + i)));
    end
    chk("ovf_pending",  32'(PENDING),   32'd4);
    chk("ovf_full",     32'(DESC_FULL), 32'd1);
    chk("ovf_overflow", 32'(OVERFLOW),  32'd1);
    busy_cycles = 3;
    wait_drain("ovf", 6000);
    chk("ovf_sticky", 32'(OVERFLOW),  32'd1);
    chk("ovf_unfull", 32'(DESC_FULL), 32'd0);

    // BUSY never rises: START must give up after the timeout.
    busy_en = 1'b0;
    write_desc(10'd16, 1'b1, mk(2'd2, 1'b1, 2'd2, 16'h0010));
    wait_drain("tmo", 3000);
    chk("tmo_run_cycles", 32'(mon_last_run), 32'd1023);
    busy_en = 1'b1;

    // Reset while WAIT with BUSY high and two descriptors queued.
    busy_cycles = 200;
    write_desc(10'd16, 1'b1, mk(2'd1, 1'b1, 2'd2, 16'h0010));
    wait_state("rstw_wait", ST_WAIT, 200);
    write_desc(10'd7, 1'b0, '0);
    write_desc(10'd8, 1'b0, '0);
    chk("rstw_pending_before", 32'(PENDING), 32'd2);
    RST        = 1'b1;
    DESC_IN    = 10'd9;
    DESC_WRITE = 1'b1;
    @(negedge CLK);
    exp_q.delete();
    mon_runcnt = 0;
    mon_ran    = 1'b0;
    mon_loads  = 0;
    mon_data   = '0;
    chk("rstw_state",    32'(fsm_state),   32'(ST_IDLE));
    chk("rstw_run",      32'(RUN),         32'd0);
    chk("rstw_pending",  32'(PENDING),     32'd0);
    chk("rstw_addr",     32'(INTRFC_ADDR), 32'h009);
    chk("rstw_done",     32'(DONE_IRQ),    32'd0);
    chk("rstw_err",      32'(ERR_IRQ),     32'd0);
    chk("rstw_overflow", 32'(OVERFLOW),    32'd0);
    RST        = 1'b0;
    DESC_WRITE = 1'b0;
    repeat (10) @(negedge CLK);
    chk("rstw_pending_after", 32'(PENDING), 32'd0);
    chk("rstw_idle_after",    32'(fsm_state), 32'(ST_IDLE));
    chk("rstw_no_run_after",  32'(RUN),     32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
